// File: rtl/video_fill_engine_if.sv
// Peripheral-bus write channel between the fill engine (initiator) and the arbiter/framebuffer side.
interface video_fill_engine_if;
  logic        bus_request;
  logic        bus_grant;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_write_enable;
  logic        bus_read_enable;

  modport master (
    output bus_request, bus_address, bus_write_data, bus_byte_enable,
           bus_write_enable, bus_read_enable,
    input  bus_grant
  );

  modport slave (
    input  bus_request, bus_address, bus_write_data, bus_byte_enable,
           bus_write_enable, bus_read_enable,
    output bus_grant
  );
endinterface

// File: rtl/video_fill_engine.sv
// Solid-colour rectangle fill: clips to the screen, then walks the rectangle row-major,
// coalescing aligned 4-pixel runs into word writes and writing all other pixels as byte writes.
module video_fill_engine #(
  parameter logic [31:0] FRAME0_BASE   = 32'hFF000000,
  parameter logic [31:0] FRAME1_BASE   = 32'hFF100000,
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 240
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [9:0]                 rect_x,
  input  logic [9:0]                 rect_y,
  input  logic [9:0]                 rect_width,
  input  logic [9:0]                 rect_height,
  input  logic [7:0]                 fill_color,
  input  logic                       target_frame,
  output logic                       busy,
  output logic                       done,
  video_fill_engine_if.master        bus
);

  localparam logic [10:0] W11    = 11'(SCREEN_WIDTH);
  localparam logic [10:0] H11    = 11'(SCREEN_HEIGHT);
  localparam logic [31:0] STRIDE = 32'(SCREEN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [9:0]  r_rect_x, r_rect_y, r_rect_w, r_rect_h;
  logic [7:0]  r_color;
  logic        r_frame;
  logic [9:0]  r_x_cur, r_y_cur;
  logic [10:0] r_x_end, r_y_end;
  logic [31:0] r_row_base;
  logic        r_busy, r_done, r_req;

  logic [10:0] w_x_sum, w_y_sum, w_remain, w_x_next, w_y_next;
  logic        w_empty, w_word;
  logic [3:0]  w_be;
  logic [31:0] w_base, w_row0;

  assign w_x_sum  = {1'b0, r_rect_x} + {1'b0, r_rect_w};
  assign w_y_sum  = {1'b0, r_rect_y} + {1'b0, r_rect_h};
  assign w_empty  = ({1'b0, r_rect_x} >= W11) || ({1'b0, r_rect_y} >= H11) ||
                    (r_rect_w == '0) || (r_rect_h == '0);
  assign w_base   = r_frame ? FRAME1_BASE : FRAME0_BASE;
  assign w_row0   = w_base + 32'(r_rect_y) * STRIDE;

  assign w_remain = r_x_end - {1'b0, r_x_cur};
  assign w_word   = (r_x_cur[1:0] == 2'b00) && (w_remain >= 11'd4);
  assign w_be     = w_word ? 4'b1111 : (4'b0001 << r_x_cur[1:0]);
  assign w_x_next = {1'b0, r_x_cur} + (w_word ? 11'd4 : 11'd1);
  assign w_y_next = {1'b0, r_y_cur} + 11'd1;

  // Beat fields are gated by the request so the bus reads all-zero outside WRITE.
  assign bus.bus_request      = r_req;
  assign bus.bus_address      = r_req ? (r_row_base + 32'(r_x_cur)) : '0;
  assign bus.bus_write_data   = r_req ? {4{r_color}} : '0;
  assign bus.bus_byte_enable  = r_req ? w_be : '0;
  assign bus.bus_write_enable = r_req && bus.bus_grant;
  assign bus.bus_read_enable  = 1'b0;

  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rect_x   <= '0;
      r_rect_y   <= '0;
      r_rect_w   <= '0;
      r_rect_h   <= '0;
      r_color    <= '0;
      r_frame    <= 1'b0;
      r_x_cur    <= '0;
      r_y_cur    <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_row_base <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rect_x <= rect_x;
            r_rect_y <= rect_y;
            r_rect_w <= rect_width;
            r_rect_h <= rect_height;
            r_color  <= fill_color;
            r_frame  <= target_frame;
            r_busy   <= 1'b1;
            r_state  <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x_end    <= (w_x_sum > W11) ? W11 : w_x_sum;
            r_y_end    <= (w_y_sum > H11) ? H11 : w_y_sum;
            r_x_cur    <= r_rect_x;
            r_y_cur    <= r_rect_y;
            r_row_base <= w_row0;
            r_req      <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.bus_grant) begin
            if (w_x_next == r_x_end) begin
              if (w_y_next == r_y_end) begin
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_x_cur    <= r_rect_x;
                r_y_cur    <= w_y_next[9:0];
                r_row_base <= r_row_base + STRIDE;
              end
            end else begin
              r_x_cur <= w_x_next[9:0];
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
